// File: rtl/cache_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cache_arb_types
// Shared types and default widths for the icache/dcache physical-memory
// arbiter (cache_mem_arbiter and its grant selector).
//   S_ADDR_W    : default line address width in bits
//   S_LINE_W    : default cache line width in bits
//   arb_state_t : transaction sequencer states
//   arb_grant_t : which cache owns the memory port
// -----------------------------------------------------------------------------
package cache_arb_types;

   localparam int S_ADDR_W = 32;
   localparam int S_LINE_W = 256;

   typedef enum logic [2:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP_I,
      RESP_D
   } arb_state_t;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } arb_grant_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_if
// Bundles the icache, dcache and physical-memory line ports of the arbiter.
//   master modport : the arbiter's view (requests and pmem_rdata/resp in;
//                    rdata, resps, pmem strobes/address/wdata out)
//   slave modport  : the environment's view (caches plus memory), mirrored
// Parameters: s_addr (address width), s_line (line width).
// -----------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
   parameter int s_addr = cache_arb_types::S_ADDR_W,
   parameter int s_line = cache_arb_types::S_LINE_W
);

   // icache side
   logic              i_read;
   logic [s_addr-1:0] i_address;
   logic [s_line-1:0] i_rdata;
   logic              i_resp;

   // dcache side
   logic              d_read;
   logic              d_write;
   logic [s_addr-1:0] d_address;
   logic [s_line-1:0] d_wdata;
   logic [s_line-1:0] d_rdata;
   logic              d_resp;

   // physical memory side
   logic              pmem_read;
   logic              pmem_write;
   logic [s_addr-1:0] pmem_address;
   logic [s_line-1:0] pmem_wdata;
   logic [s_line-1:0] pmem_rdata;
   logic              pmem_resp;

   modport master (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport slave (
      output i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );

endinterface

// File: rtl/cache_mem_arbiter_select.sv
// -----------------------------------------------------------------------------
// cache_arb_select
// Combinational grant decision for the memory arbiter.
//   i_req       : icache wants the memory port
//   d_req       : dcache wants the memory port (read or writeback)
//   last_grant  : requester granted most recently
//   grant       : winner of this evaluation
//   grant_valid : at least one request is pending
// Build option CACHE_ARB_ROUND_ROBIN_EN: when defined, contention is resolved
// in favour of the requester that was not granted last; otherwise the dcache
// always wins contention.
// -----------------------------------------------------------------------------
module cache_arb_select
   import cache_arb_types::*;
(
   input  logic       i_req,
   input  logic       d_req,
   input  arb_grant_t last_grant,
   output arb_grant_t grant,
   output logic       grant_valid
);

   assign grant_valid = i_req | d_req;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
   always_comb begin
      grant = GRANT_D;
      if (i_req && !d_req) begin
         grant = GRANT_I;
      end else if (i_req && d_req && (last_grant == GRANT_D)) begin
         grant = GRANT_I;
      end
   end
`else
   // Fixed priority ignores the pointer; the port stays so both builds
   // present the same boundary to the top.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      grant = d_req ? GRANT_D : GRANT_I;
   end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Shares one physical-memory line port between the icache and the dcache.
// A pending request seen in IDLE is granted, its address (and writeback line)
// latched, one memory transaction is run, and the winner receives a registered
// one-cycle resp. A mandatory IDLE cycle separates transactions.
//   clk  : system clock
//   rst  : asynchronous, active-high reset (aborts any transaction)
//   bus  : cache_mem_arbiter_if.master (icache, dcache and pmem ports)
// Parameters: s_addr (address width), s_line (line width).
// Build option CACHE_ARB_ROUND_ROBIN_EN: adds a last-grant pointer so that
// contention alternates between the caches instead of favouring the dcache.
// -----------------------------------------------------------------------------
module cache_mem_arbiter
   import cache_arb_types::*;
#(
   parameter int s_addr = S_ADDR_W,
   parameter int s_line = S_LINE_W
)(
   input  logic                clk,
   input  logic                rst,
   cache_mem_arbiter_if.master bus
);

   arb_state_t        state_q;
   arb_state_t        state_d;
   arb_grant_t        grant;
   arb_grant_t        last_grant;
   logic              grant_valid;
   logic              take_grant;
   logic              grant_write;
   logic              is_write_q;
   logic [s_addr-1:0] address_q;
   logic [s_line-1:0] wdata_q;
   logic [s_line-1:0] i_rdata_q;
   logic [s_line-1:0] d_rdata_q;

   cache_arb_select u_select (
      .i_req       (bus.i_read),
      .d_req       (bus.d_read | bus.d_write),
      .last_grant  (last_grant),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Requests are only looked at in IDLE; everywhere else they are ignored.
   assign take_grant  = (state_q == IDLE) && grant_valid;
   // A dcache write wins over a simultaneous dcache read.
   assign grant_write = (grant == GRANT_D) && bus.d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
   arb_grant_t last_q;

   // Starts at GRANT_I so the dcache wins the first contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= GRANT_I;
      end else if (take_grant) begin
         last_q <= grant;
      end
   end

   assign last_grant = last_q;
`else
   assign last_grant = GRANT_I;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values present before the clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: state_d gets its default before the case so every path assigns it
   // and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d = (grant == GRANT_D) ? BUSY_D : BUSY_I;
            end
         end
         BUSY_I: begin
            if (bus.pmem_resp) state_d = RESP_I;
         end
         BUSY_D: begin
            if (bus.pmem_resp) state_d = RESP_D;
         end
         RESP_I, RESP_D: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Address/line capture at grant, read data capture at memory completion.
   // Write completions leave d_rdata untouched; rdata holds until overwritten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         address_q  <= '0;
         wdata_q    <= '0;
         is_write_q <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (take_grant) begin
            address_q  <= (grant == GRANT_D) ? bus.d_address : bus.i_address;
            is_write_q <= grant_write;
            if (grant_write) begin
               wdata_q <= bus.d_wdata;
            end
         end
         if ((state_q == BUSY_I) && bus.pmem_resp) begin
            i_rdata_q <= bus.pmem_rdata;
         end
         if ((state_q == BUSY_D) && bus.pmem_resp && !is_write_q) begin
            d_rdata_q <= bus.pmem_rdata;
         end
      end
   end

   // Strobes and resps decode straight from registered state, so reset
   // clears them without waiting for a clock edge.
   assign bus.pmem_read    = (state_q == BUSY_I) || ((state_q == BUSY_D) && !is_write_q);
   assign bus.pmem_write   = (state_q == BUSY_D) && is_write_q;
   assign bus.pmem_address = address_q;
   assign bus.pmem_wdata   = wdata_q;
   assign bus.i_resp       = (state_q == RESP_I);
   assign bus.d_resp       = (state_q == RESP_D);
   assign bus.i_rdata      = i_rdata_q;
   assign bus.d_rdata      = d_rdata_q;

   // Read and writeback together from the dcache is a protocol error; the
   // write is still issued, but simulation flags it.
   assert property (@(posedge clk) disable iff (rst)
      (state_q == IDLE) |-> !(bus.d_read && bus.d_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Self-checking bench for cache_mem_arbiter. A transaction-level reference
// (idle / active / resp phases, arbitration rule, line memory) predicts every
// cycle's strobes, resps, address, write line and rdata registers. Directed
// vectors, hand sequences (reset abort, contention rounds, requester drop,
// stray memory resp) and a randomized run all go through the same cycle step.
// Honours CACHE_ARB_ROUND_ROBIN_EN for the expected arbitration rule.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;
   import cache_arb_types::*;

   localparam int A = S_ADDR_W;
   localparam int L = S_LINE_W;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_mem_arbiter_if #(.s_addr(A), .s_line(L)) bus ();

   cache_mem_arbiter #(.s_addr(A), .s_line(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef enum {PH_IDLE, PH_ACT, PH_RESP} phase_t;

   typedef struct {
      bit          req_i;
      bit          req_d;
      bit          d_wr;
      logic [31:0] i_addr;
      logic [31:0] d_addr;
      logic [15:0] wpat;
      int          mwait;
      int          exp_i_lat;  // cycles from request to i_resp, -1 = none
      int          exp_d_lat;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model
   phase_t          ph;
   bit              cur_d, cur_wr, last_d;
   logic [A-1:0]    cur_addr;
   logic [L-1:0]    cur_wdata;
   int              wait_tgt, wait_cnt;
   logic [L-1:0]    exp_i_rdata, exp_d_rdata;
   logic [L-1:0]    mem [logic [A-1:0]];

   // cache agents and memory behaviour
   bit              i_pend, d_pend, d_wr_pend;
   logic [A-1:0]    i_addr_v, d_addr_v;
   logic [L-1:0]    d_wdata_v;
   bit              rand_mode;
   int              fixed_wait;
   int              stray_pct;

   // observations of the DUT
   int              i_resp_cyc, d_resp_cyc;
   bit              resp_log [$];

   vec_t            vecs [6];

   task automatic check(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [L-1:0] rand_line();
      logic [L-1:0] r;
      for (int k = 0; k < L / 32; k++) r[k*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [L-1:0] line_of(input logic [A-1:0] a);
      if (mem.exists(a)) return mem[a];
      return {(L / A){a ^ 32'h5EED_0000}};
   endfunction

   function automatic logic [A-1:0] rand_addr();
      return 32'h0000_4000 + ($urandom_range(7) << 5);
   endfunction

   function automatic int lat_of(input int c, input int c0);
      return (c < 0) ? -1 : c - c0;
   endfunction

   task automatic drive_inputs();
      bus.i_read    = i_pend;
      bus.i_address = i_pend ? i_addr_v : $urandom();
      bus.d_read    = d_pend && !d_wr_pend;
      bus.d_write   = d_pend && d_wr_pend;
      bus.d_address = d_pend ? d_addr_v : $urandom();
      bus.d_wdata   = d_pend ? d_wdata_v : rand_line();
   endtask

   task automatic model_reset();
      ph          = PH_IDLE;
      last_d      = 1'b0;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      i_pend      = 1'b0;
      d_pend      = 1'b0;
      d_wr_pend   = 1'b0;
      drive_inputs();
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
   endtask

   // One clock: check what the DUT shows now, then drive the next inputs and
   // advance the reference.
   task automatic step();
      logic [3:0] exp_ctl;
      @(negedge clk);
      cyc++;
      if (bus.i_resp === 1'b1) begin
         resp_log.push_back(1'b0);
         if (i_resp_cyc < 0) i_resp_cyc = cyc;
      end
      if (bus.d_resp === 1'b1) begin
         resp_log.push_back(1'b1);
         if (d_resp_cyc < 0) d_resp_cyc = cyc;
      end

      exp_ctl = {(ph == PH_ACT) && !cur_wr, (ph == PH_ACT) && cur_wr,
                 (ph == PH_RESP) && !cur_d, (ph == PH_RESP) && cur_d};
      check("rd_wr_iresp_dresp", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, exp_ctl);
      if (ph == PH_ACT) begin
         check("pmem_address", bus.pmem_address, cur_addr);
         if (cur_wr) check("pmem_wdata", bus.pmem_wdata, cur_wdata);
      end
      check("i_rdata", bus.i_rdata, exp_i_rdata);
      check("d_rdata", bus.d_rdata, exp_d_rdata);

      // requesters drop in their resp cycle, then may request again
      if (ph == PH_RESP) begin
         if (cur_d) d_pend = 1'b0;
         else       i_pend = 1'b0;
      end
      if (rand_mode) begin
         if (!i_pend && ($urandom_range(3) == 0)) begin
            i_pend   = 1'b1;
            i_addr_v = rand_addr();
         end
         if (!d_pend && ($urandom_range(3) == 0)) begin
            d_pend    = 1'b1;
            d_wr_pend = $urandom_range(1);
            d_addr_v  = rand_addr();
            d_wdata_v = rand_line();
         end
      end
      drive_inputs();

      // memory: answers after the chosen wait, otherwise junk and stray resps
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = rand_line();
      if (ph == PH_ACT) begin
         if (wait_cnt == wait_tgt) begin
            bus.pmem_resp = 1'b1;
            if (bus.pmem_write) mem[bus.pmem_address] = bus.pmem_wdata;
            else                bus.pmem_rdata = line_of(bus.pmem_address);
         end
         wait_cnt++;
      end else if ($urandom_range(99) < stray_pct) begin
         bus.pmem_resp = 1'b1;
      end

      case (ph)
         PH_IDLE: begin
            if (i_pend || d_pend) begin
               cur_d     = RR ? (d_pend && (!i_pend || !last_d)) : d_pend;
               last_d    = cur_d;
               cur_wr    = cur_d && d_wr_pend;
               cur_addr  = cur_d ? d_addr_v : i_addr_v;
               cur_wdata = d_wdata_v;
               wait_cnt  = 0;
               wait_tgt  = rand_mode ? $urandom_range(3) : fixed_wait;
               ph        = PH_ACT;
            end
         end
         PH_ACT: begin
            if (bus.pmem_resp) begin
               if (!cur_wr) begin
                  if (cur_d) exp_d_rdata = line_of(cur_addr);
                  else       exp_i_rdata = line_of(cur_addr);
               end
               ph = PH_RESP;
            end
         end
         default: ph = PH_IDLE;
      endcase
   endtask

   // Runs until the reference is idle with nothing pending (bounded).
   task automatic run_txn(input int budget);
      int n;
      n = 0;
      step();
      while ((i_pend || d_pend || (ph != PH_IDLE)) && (n < budget)) begin
         step();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;

      rand_mode  = 1'b0;
      stray_pct  = 0;
      fixed_wait = 0;
      i_resp_cyc = -1;
      d_resp_cyc = -1;
      mem[32'h0000_1040] = {32{8'hA5}};
      rst = 1'b1;
      model_reset();

      // reset values
      step();
      step();
      check("rst_pmem_address", bus.pmem_address, '0);
      check("rst_pmem_wdata", bus.pmem_wdata, '0);
      rst = 1'b0;
      step();

      // directed vectors: {req_i, req_d, d_wr, i_addr, d_addr, wpat, wait, i_lat, d_lat}
      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1040, 32'h0, 16'h0, 3, 5, -1};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_2000, 16'h1234, 2, -1, 4};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_1040, 32'h0000_2000, 16'h0, 0,
                  RR ? 2 : 5, RR ? 5 : 2};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000, 16'hBEEF, 1,
                  RR ? 3 : 7, RR ? 7 : 3};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_3000, 16'h0, 0, -1, 2};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h0000_1040, 16'h0, 2,
                  RR ? 4 : 9, RR ? 9 : 4};

      for (int k = 0; k < 6; k++) begin
         i_resp_cyc = -1;
         d_resp_cyc = -1;
         c0         = cyc + 1;
         fixed_wait = vecs[k].mwait;
         i_pend     = vecs[k].req_i;
         i_addr_v   = vecs[k].i_addr;
         d_pend     = vecs[k].req_d;
         d_wr_pend  = vecs[k].d_wr;
         d_addr_v   = vecs[k].d_addr;
         d_wdata_v  = {16{vecs[k].wpat}};
         run_txn(60);
         check($sformatf("vec%0d_i_resp_latency", k), lat_of(i_resp_cyc, c0), vecs[k].exp_i_lat);
         check($sformatf("vec%0d_d_resp_latency", k), lat_of(d_resp_cyc, c0), vecs[k].exp_d_lat);
      end

      // contention rounds: D then I in each of three rounds
      fixed_wait = 1;
      i_pend     = 1'b1;
      i_addr_v   = 32'h0000_1040;
      run_txn(40);
      resp_log.delete();
      for (int r = 0; r < 3; r++) begin
         i_pend    = 1'b1;
         i_addr_v  = rand_addr();
         d_pend    = 1'b1;
         d_wr_pend = 1'b0;
         d_addr_v  = rand_addr();
         run_txn(40);
      end
      check("rounds_resp_count", resp_log.size(), 6);
      for (int k = 0; k < 6; k++) begin
         if (k < resp_log.size())
            check($sformatf("rounds_order%0d", k), resp_log[k], (k % 2 == 0));
      end

      // icache drops its request mid-transaction; address lines change too
      i_resp_cyc = -1;
      fixed_wait = 3;
      i_pend     = 1'b1;
      i_addr_v   = 32'h0000_5040;
      step();
      step();
      i_pend = 1'b0;
      run_txn(40);
      check("drop_i_resp_seen", (i_resp_cyc >= 0), 1'b1);

      // stray memory resps in IDLE: nothing may move
      stray_pct  = 100;
      i_resp_cyc = -1;
      d_resp_cyc = -1;
      repeat (4) step();
      stray_pct = 0;
      check("stray_no_i_resp", i_resp_cyc, -1);
      check("stray_no_d_resp", d_resp_cyc, -1);

      // asynchronous reset while the dcache read is in flight
      fixed_wait = 10;
      d_pend     = 1'b1;
      d_wr_pend  = 1'b0;
      d_addr_v   = 32'h0000_6000;
      step();
      step();
      step();
      d_resp_cyc = -1;
      #2 rst = 1'b1;
      #1;
      check("abort_strobes_resps",
            {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, '0);
      check("abort_pmem_address", bus.pmem_address, '0);
      check("abort_pmem_wdata", bus.pmem_wdata, '0);
      check("abort_i_rdata", bus.i_rdata, '0);
      check("abort_d_rdata", bus.d_rdata, '0);
      model_reset();
      step();
      step();
      rst = 1'b0;
      repeat (4) step();
      check("abort_no_d_resp", d_resp_cyc, -1);

      // randomized traffic with stray resps
      rand_mode = 1'b1;
      stray_pct = 25;
      repeat (3000) step();
      rand_mode = 1'b0;
      stray_pct = 0;
      run_txn(60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port (the cacheline adaptor side) between the instruction cache and the data cache.
- Each cache holds a line-granular miss or writeback request until it gets a one-cycle response.
- The arbiter grants one requester at a time, latches its address and data, and sequences one memory transaction.
- It then returns the line to the winner with a registered one-cycle response.

Parameters:
s_addr, 32, address width in bits (line-aligned addresses; low bits are passed through unchanged)
s_line, 256, cache line width in bits

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
i_read  in  1  icache line-read request, held until i_resp
i_address  in  s_addr  icache request address
i_rdata  out  s_line  line returned to icache, valid when i_resp=1
i_resp  out  1  one-cycle completion pulse to icache
d_read  in  1  dcache line-read request, held until d_resp
d_write  in  1  dcache line-writeback request, held until d_resp
d_address  in  s_addr  dcache request address
d_wdata  in  s_line  dcache writeback line
d_rdata  out  s_line  line returned to dcache, valid when d_resp=1
d_resp  out  1  one-cycle completion pulse to dcache
pmem_read  out  1  memory-side read strobe, held for the whole transaction
pmem_write  out  1  memory-side write strobe, held for the whole transaction
pmem_address  out  s_addr  memory-side address (registered)
pmem_wdata  out  s_line  memory-side write line (registered)
pmem_rdata  in  s_line  memory-side read line, valid with pmem_resp
pmem_resp  in  1  memory-side completion, one cycle

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: FSM=IDLE, all out ports 0 (strobes, resps, pmem_address, pmem_wdata, i_rdata, d_rdata). `rst` asserted mid-transaction aborts it immediately: strobes drop, no resp is issued, and the memory model must tolerate the abandoned access.
- FSM states and transitions:
  - IDLE: evaluate requests. On a grant, latch address (plus d_wdata if a write) into pmem_address/pmem_wdata and go to BUSY_I or BUSY_D.
  - BUSY_I / BUSY_D: pmem_read (or pmem_write) held high from registered state. On pmem_resp=1, capture pmem_rdata into the winner's rdata register and go to RESP_I / RESP_D.
  - RESP_I / RESP_D: winner's resp=1 for exactly one cycle, strobes low. Return to IDLE unconditionally.
- Latency: request visible in IDLE at cycle 0 -> pmem strobe from cycle 1 -> pmem_resp at cycle N -> x_resp at cycle N+1.
  - Minimum turnaround is 3 cycles with zero memory wait.
  - There is one mandatory IDLE bubble between transactions, so the arbiter never sees a request the requester is deasserting in its resp cycle.
- Arbitration (default): dcache has fixed priority over icache on simultaneous requests in IDLE.
- d_read and d_write both high is illegal. d_write wins, a write transaction is issued, and simulation asserts.
- Requester deasserting mid-transaction: the transaction still completes and resp is still pulsed. Inputs are ignored outside IDLE (address/data are not re-sampled).
- pmem_resp seen in IDLE or RESP states: ignored, no state change.
- Write transactions: pmem_rdata is not captured, and d_rdata retains its previous value.
- rdata registers hold their value until the next capture; they are not cleared after resp.

Optional Feature:
- Macro: CACHE_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-grant register (reset to I, so D wins the first contention) is updated at each grant. On simultaneous requests in IDLE, the requester not granted last wins. Uncontended requests are granted immediately regardless of the pointer.
- Undefined: fixed dcache priority and no pointer register.

Decomposition:
- Package cache_arb_types:
  - enum arb_state_t {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D}
  - enum arb_grant_t {GRANT_I, GRANT_D}
  - localparams for the default widths
- Sub-module cache_arb_select: combinational grant logic (requests plus last-grant pointer in, arb_grant_t plus grant-valid out). It is the only part that changes under CACHE_ARB_ROUND_ROBIN_EN.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle during BUSY_D -> all outputs 0 before the next clk edge, FSM IDLE, no d_resp ever pulsed for that access.
- Icache miss alone: i_read=1, i_address=0x0000_1040, memory responds 4 cycles after strobe with rdata=0xA5 pattern -> pmem_read high on cycles 1-4, pmem_address=0x0000_1040, i_resp=1 on cycle 5 with i_rdata=0xA5 pattern, d_resp stays 0.
- Writeback: d_write=1, d_address=0x0000_2000, d_wdata=0x1234 pattern -> pmem_write=1 with pmem_wdata=0x1234 pattern held until pmem_resp, d_resp pulse one cycle later, pmem_read never high, d_rdata unchanged.
- Contention, fixed priority: i_read and d_read both rise at cycle 0 ->
  - dcache is served first; after d_resp and the IDLE bubble, the icache is served with pmem_address=i_address.
  - i_resp arrives exactly 3 cycles plus the memory wait after d_resp.
- Contention, CACHE_ARB_ROUND_ROBIN_EN: both caches request back-to-back repeatedly over 3 rounds -> grants alternate D, I, D, I, D, I.
- Requester drop and stray resp: i_read dropped during BUSY_I -> i_resp still pulsed. pmem_resp=1 injected in IDLE -> no resp and no state change.
